// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window front end: sequencer states,
// border flag bit positions and the window priming length.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int unsigned BORDER_LEFT   = 0;
    localparam int unsigned BORDER_RIGHT  = 1;
    localparam int unsigned BORDER_TOP    = 2;
    localparam int unsigned BORDER_BOTTOM = 3;

    localparam int unsigned KERNEL_SIZE = 3;

    // Shifts needed before the window centre reaches pixel (0,0).
    function automatic int unsigned prime_len(input int unsigned line_width);
        return (KERNEL_SIZE / 2) * line_width + (KERNEL_SIZE / 2);
    endfunction

endpackage

// File: rtl/pos_counter.sv
// Column/row position counter: advances on en, wraps at the line and frame
// edges, and restarts at (0,0) on clr (or at (1,0) when clr and en coincide).
module pos_counter #(
    parameter int unsigned COLS = 1920,
    parameter int unsigned ROWS = 1080
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(COLS)-1:0]  col,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic                     col_last_c,
    output logic                     row_last_c
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    assign col_last_c = (col == CW'(COLS - 1));
    assign row_last_c = (row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= en ? CW'(1) : '0;
            row <= '0;
        end else if (en) begin
            if (col_last_c) begin
                col <= '0;
                row <= row_last_c ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Frame sequencer for the 3x3 Sobel line delays: primes, runs and flushes the
// window and tags each centre. Define LINE_BUF_CTRL_ERR_EN for framing checks.
module line_buf_ctrl #(
    parameter int unsigned LINE_WIDTH   = 1920,
    parameter int unsigned FRAME_HEIGHT = 1080,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_sof,
    input  logic                            s_eol,
    output logic                            ld_shift,
    output logic [DATA_WIDTH-1:0]           ld_pixel,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(LINE_WIDTH)-1:0]   m_col,
    output logic [$clog2(FRAME_HEIGHT)-1:0] m_row,
    output logic [3:0]                      m_border,
    output logic                            m_sof,
    output logic                            m_eof,
    output logic                            err
);

    import sobel_pkg::*;

    localparam int unsigned CW        = $clog2(LINE_WIDTH);
    localparam int unsigned RW        = $clog2(FRAME_HEIGHT);
    localparam int unsigned PRIME_LEN = prime_len(LINE_WIDTH);
    localparam int unsigned PCW       = $clog2(PRIME_LEN + 1);

    state_t         state, state_nxt;
    logic [PCW-1:0] prime_cnt;
    logic           stall, acc, sof_acc, in_shift, flush_shift;
    logic           pix_last, prime_done, emit, eol_err, err_nxt, out_last;
    logic [3:0]     border_nxt;

    logic [CW-1:0]  in_col, out_col;
    logic [RW-1:0]  in_row, out_row;
    logic           in_col_last_c, in_row_last_c, out_col_last_c, out_row_last_c;

    pos_counter #(.COLS(LINE_WIDTH), .ROWS(FRAME_HEIGHT)) u_in_pos (
        .clk        (clk),
        .rst        (rst),
        .clr        (sof_acc),
        .en         (in_shift),
        .col        (in_col),
        .row        (in_row),
        .col_last_c (in_col_last_c),
        .row_last_c (in_row_last_c)
    );

    pos_counter #(.COLS(LINE_WIDTH), .ROWS(FRAME_HEIGHT)) u_out_pos (
        .clk        (clk),
        .rst        (rst),
        .clr        (sof_acc),
        .en         (emit),
        .col        (out_col),
        .row        (out_row),
        .col_last_c (out_col_last_c),
        .row_last_c (out_row_last_c)
    );

    // Only the wrap flags of the input position are needed.
    logic unused_in_pos;
    assign unused_in_pos = ^{in_col, in_row};

`ifndef LINE_BUF_CTRL_ERR_EN
    logic unused_eol;
    assign unused_eol = s_eol;
`endif

    // Handshake, shift strobe, tag generation and next state.
    always_comb begin
        state_nxt   = state;
        stall       = m_valid && !m_ready;
        s_ready     = !rst && !stall && (state != FLUSH);
        acc         = s_valid && s_ready;
        sof_acc     = acc && s_sof;
        in_shift    = acc && (s_sof || (state != IDLE));
        flush_shift = !rst && (state == FLUSH) && !stall;
        ld_shift    = in_shift || flush_shift;
        ld_pixel    = (state == FLUSH) ? '0 : s_data;
        prime_done  = (prime_cnt == PCW'(PRIME_LEN));
        pix_last    = in_shift && !s_sof && in_col_last_c && in_row_last_c;
        out_last    = out_col_last_c && out_row_last_c;
`ifdef LINE_BUF_CTRL_ERR_EN
        eol_err     = in_shift && (s_eol != (!s_sof && in_col_last_c));
        err_nxt     = eol_err || (sof_acc && ((state == PRIME) || (state == RUN)));
`else
        eol_err     = 1'b0;
        err_nxt     = 1'b0;
`endif
        emit        = !eol_err &&
                      ((in_shift && !s_sof &&
                        ((state == RUN) || ((state == PRIME) && prime_done))) ||
                       flush_shift);

        border_nxt                   = '0;
        border_nxt[2'(BORDER_LEFT)]   = (out_col == '0);
        border_nxt[2'(BORDER_RIGHT)]  = out_col_last_c;
        border_nxt[2'(BORDER_TOP)]    = (out_row == '0);
        border_nxt[2'(BORDER_BOTTOM)] = out_row_last_c;

        case (state)
            IDLE:    state_nxt = state;
            PRIME: begin
                if (in_shift) begin
                    if (pix_last)        state_nxt = FLUSH;
                    else if (prime_done) state_nxt = RUN;
                end
            end
            RUN:     if (pix_last) state_nxt = FLUSH;
            FLUSH:   if (flush_shift && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A framing error abandons the frame; any accepted SOF restarts it.
        if (eol_err)      state_nxt = IDLE;
        else if (sof_acc) state_nxt = PRIME;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Priming shift index and the registered tag stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
            m_valid   <= 1'b0;
            m_col     <= '0;
            m_row     <= '0;
            m_border  <= '0;
            m_sof     <= 1'b0;
            m_eof     <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= err_nxt;

            if (sof_acc)
                prime_cnt <= PCW'(1);
            else if ((state == PRIME) && in_shift && !prime_done)
                prime_cnt <= prime_cnt + PCW'(1);

            if (eol_err || sof_acc) begin
                m_valid <= 1'b0;
            end else if (emit) begin
                m_valid  <= 1'b1;
                m_col    <= out_col;
                m_row    <= out_row;
                m_border <= border_nxt;
                m_sof    <= (out_col == '0) && (out_row == '0);
                m_eof    <= out_last;
            end else if (m_ready) begin
                m_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl on a 4x3 frame: cycle vector table plus
// streamed sequences for backpressure, restart, eol error and reset in flush.
module tb_line_buf_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned DW = 8;
`ifdef LINE_BUF_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_sof, s_eol;
    logic [DW-1:0] s_data, ld_pixel;
    logic          ld_shift, m_valid, m_ready, m_sof, m_eof, err;
    logic [1:0]    m_col, m_row;
    logic [3:0]    m_border;

    always #5 clk = ~clk;

    line_buf_ctrl #(.LINE_WIDTH(W), .FRAME_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .s_eol    (s_eol),
        .ld_shift (ld_shift),
        .ld_pixel (ld_pixel),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_col    (m_col),
        .m_row    (m_row),
        .m_border (m_border),
        .m_sof    (m_sof),
        .m_eof    (m_eof),
        .err      (err)
    );

    typedef struct {
        logic       sv, sof, eol;
        logic [7:0] dat;
        logic       e_sr, e_sh;
        logic [7:0] e_px;
        logic       e_mv;
        logic [1:0] e_col, e_row;
        logic [3:0] e_bd;
        logic       e_sof, e_eof;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    int   tq[$];
    int   tcyc[$];
    int   nshift, err_cnt, err_cyc, sof2_cyc;
    logic bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic sof, input logic eol,
                                input logic [7:0] dat, input logic e_sr, input logic e_sh,
                                input logic [7:0] e_px, input logic e_mv,
                                input logic [1:0] e_col, input logic [1:0] e_row,
                                input logic [3:0] e_bd, input logic e_sof, input logic e_eof);
        vec_t v;
        v.sv = sv; v.sof = sof; v.eol = eol; v.dat = dat;
        v.e_sr = e_sr; v.e_sh = e_sh; v.e_px = e_px; v.e_mv = e_mv;
        v.e_col = e_col; v.e_row = e_row; v.e_bd = e_bd; v.e_sof = e_sof; v.e_eof = e_eof;
        return v;
    endfunction

    function automatic int pack_exp(input vec_t v);
        return int'({v.e_sr, v.e_sh, v.e_px, v.e_mv,
                     v.e_mv ? {v.e_col, v.e_row, v.e_bd, v.e_sof, v.e_eof} : 10'b0, 1'b0});
    endfunction

    function automatic int pack_obs();
        return int'({s_ready, ld_shift, ld_pixel, m_valid,
                     m_valid ? {m_col, m_row, m_border, m_sof, m_eof} : 10'b0, err});
    endfunction

    function automatic int cur_tag();
        return int'({m_col, m_row, m_border, m_sof, m_eof});
    endfunction

    // Expected tag for the i-th centre of a frame, in raster order.
    function automatic int exp_tag(input int i);
        logic [1:0] c, r;
        logic [3:0] bd;
        c  = 2'(i % W);
        r  = 2'(i / W);
        bd = {r == 2'(H - 1), r == 2'd0, c == 2'(W - 1), c == 2'd0};
        return int'({c, r, bd, i == 0, i == int'(W * H - 1)});
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk); #1;
            s_valid = tbl[i].sv;
            s_sof   = tbl[i].sof;
            s_eol   = tbl[i].eol;
            s_data  = tbl[i].dat;
            m_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d", i), pack_obs(), pack_exp(tbl[i]));
        end
    endtask

    // Stream npix pixels (SOF on pixel 0 and on pixel sof2, eol toggled
    // wrongly on pixel bad_eol), optionally with m_ready backpressure.
    task automatic stream(input int npix, input int sof2, input int bad_eol, input bit bp);
        int idx, cyc, tail, fidx, prev_tag;
        bit prev_stall;
        idx = 0; cyc = 0; tail = 0; prev_stall = 1'b0; prev_tag = 0;
        tq.delete(); tcyc.delete();
        nshift = 0; err_cnt = 0; err_cyc = -1; sof2_cyc = -1;
        while (tail < 30 && cyc < 300) begin
            @(posedge clk); #1;
            fidx    = (sof2 >= 0 && idx >= sof2) ? idx - sof2 : idx;
            s_valid = (idx < npix);
            s_sof   = s_valid && (idx == 0 || idx == sof2);
            s_eol   = s_valid && (((fidx % W) == W - 1) ^ (idx == bad_eol));
            s_data  = 8'(idx + 1);
            m_ready = bp ? bp_pat[cyc % 4] : 1'b1;
            #1;
            if (m_valid && !m_ready)
                chk("stall_hold", int'({s_ready, ld_shift}), 0);
            if (prev_stall)
                chk("tag_stable", m_valid ? cur_tag() : -1, prev_tag);
            prev_stall = m_valid && !m_ready;
            prev_tag   = cur_tag();
            if (ld_shift) nshift++;
            if (m_valid && m_ready) begin
                tq.push_back(cur_tag());
                tcyc.push_back(cyc);
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (s_valid && s_ready) begin
                if (idx == sof2) sof2_cyc = cyc;
                idx++;
            end
            if (idx >= npix) tail++;
            cyc++;
        end
        chk("stream_done", idx, npix);
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; m_ready = 1'b1;
    endtask

    task automatic chk_frame_tags(input string name, input int base);
        for (int i = 0; i < 12 && base + i < tq.size(); i++)
            chk($sformatf("%s_tag%0d", name, i), tq[base + i], exp_tag(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cycle table for one 4x3 frame; tags checked only while m_valid
        tbl.push_back(mk(1, 1, 0, 8'd1,  1, 1, 8'd1,  0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd2,  1, 1, 8'd2,  0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd3,  1, 1, 8'd3,  0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'd4,  1, 1, 8'd4,  0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd5,  1, 1, 8'd5,  0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd6,  1, 1, 8'd6,  0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd7,  1, 1, 8'd7,  1, 0, 0, 4'b0101, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8'd8,  1, 1, 8'd8,  1, 1, 0, 4'b0100, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd9,  1, 1, 8'd9,  1, 2, 0, 4'b0100, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd10, 1, 1, 8'd10, 1, 3, 0, 4'b0110, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd11, 1, 1, 8'd11, 1, 0, 1, 4'b0001, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'd12, 1, 1, 8'd12, 1, 1, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 8'd0,  1, 2, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 8'd0,  1, 3, 1, 4'b0010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 8'd0,  1, 0, 2, 4'b1001, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 8'd0,  1, 1, 2, 4'b1000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 8'd0,  1, 2, 2, 4'b1000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  1, 0, 8'd0,  1, 3, 2, 4'b1010, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,  1, 0, 8'd0,  0, 0, 0, 4'b0000, 0, 0));
        // junk before any SOF: accepted, never shifted
        tbl.push_back(mk(1, 0, 0, 8'hAA, 1, 0, 8'hAA, 0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'hBB, 1, 0, 8'hBB, 0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'hCC, 1, 0, 8'hCC, 0, 0, 0, 4'b0000, 0, 0));

        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_state", int'({s_ready, ld_shift, m_valid, m_col, m_row, m_border,
                               m_sof, m_eof, err}), int'(14'h2000));

        run_vecs(0, 18);
        run_vecs(19, 21);
        run_vecs(0, 18);

        stream(12, -1, -1, 1'b1);
        chk("bp_shifts", nshift, 17);
        chk("bp_count", tq.size(), 12);
        chk_frame_tags("bp", 0);

        stream(19, 7, -1, 1'b0);
        chk("rs_shifts", nshift, 24);
        chk("rs_count", tq.size(), 14);
        chk("rs_old0", tq.size() > 0 ? tq[0] : -1, exp_tag(0));
        chk("rs_old1", tq.size() > 1 ? tq[1] : -1, exp_tag(1));
        chk_frame_tags("rs", 2);
        chk("rs_first_cyc", tcyc.size() > 2 ? tcyc[2] : -1, sof2_cyc + 6);
        chk("rs_err_cnt", err_cnt, ERR_EN ? 1 : 0);
        chk("rs_err_cyc", err_cyc, ERR_EN ? sof2_cyc + 1 : -1);

        stream(12, -1, 2, 1'b0);
        chk("eol_shifts", nshift, ERR_EN ? 3 : 17);
        chk("eol_count", tq.size(), ERR_EN ? 0 : 12);
        chk("eol_err_cyc", err_cyc, ERR_EN ? 3 : -1);
        chk("eol_err_cnt", err_cnt, ERR_EN ? 1 : 0);
        chk_frame_tags("eol", 0);

        stream(12, -1, -1, 1'b0);
        chk("post_shifts", nshift, 17);
        chk("post_count", tq.size(), 12);
        chk("post_err", err_cnt, 0);
        chk_frame_tags("post", 0);

        run_vecs(0, 13);
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h55;
        #1;
        chk("rstflush_shift", int'(ld_shift), 0);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        #1;
        chk("rstflush_state", int'({m_valid, s_ready, err}), int'(3'b010));
        run_vecs(0, 18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
